cvxif_copro_exec: RTL and testbench

Execution stage of the CV-X-IF example coprocessor, directly downstream of the instruction decoder that matches offloaded instructions against the coprocessor instruction table. It accepts one decoded operation (`opcode_t`, operands, id, rd) per handshake and computes the result, in one cycle or, for `ADD_MULTI`, four. Results are buffered in a small FIFO and presented on the CV-X-IF result channel with valid/ready backpressure.

---
 rtl/cvxif_instr_pkg.sv | 47 ++++
 rtl/cvxif_result_fifo.sv | 56 +++++
 rtl/cvxif_copro_exec.sv | 161 ++++++++++++++++
 tb/tb_cvxif_copro_exec.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_instr_pkg.sv
// Shared types for the CV-X-IF example coprocessor.
// The instruction decoder and the execution stage both use this package.
//   opcode_t      : decoded operation handed from the decoder to the execution stage
//   exec_result_t : one result-channel entry (data, id, rd, we)
//   ror64_word    : 32-bit word select of a 64-bit rotate-right
package cvxif_instr_pkg;

  localparam int unsigned CoproXlen    = 32;
  localparam int unsigned CoproIdWidth = 4;

  typedef enum logic [3:0] {
    ILLEGAL      = 4'd0,
    NOP          = 4'd1,
    ADD          = 4'd2,
    DOUBLE_RS1   = 4'd3,
    DOUBLE_RS2   = 4'd4,
    ADD_MULTI    = 4'd5,
    ADD_RS3_R    = 4'd6,
    MADD_RS3_R4  = 4'd7,
    MSUB_RS3_R4  = 4'd8,
    NMADD_RS3_R4 = 4'd9,
    NMSUB_RS3_R4 = 4'd10,
    ROR64H       = 4'd11,
    OP_ASCON     = 4'd12
  } opcode_t;

  typedef struct packed {
    logic [CoproXlen-1:0]    data;
    logic [CoproIdWidth-1:0] id;
    logic [4:0]              rd;
    logic                    we;
  } exec_result_t;

  // Rotate {hi,lo} right by shamt. The pair is duplicated so that a plain
  // right shift yields the rotation, and shamt 0 passes the pair through.
  function automatic logic [31:0] ror64_word(input logic [31:0] hi,
                                             input logic [31:0] lo,
                                             input logic [5:0]  shamt,
                                             input logic        lo_sel);
    logic [127:0] dbl;
    logic [63:0]  rot;
    dbl = {hi, lo, hi, lo} >> shamt;
    rot = dbl[63:0];
    return lo_sel ? rot[31:0] : rot[63:32];
  endfunction

endpackage

// File: rtl/cvxif_result_fifo.sv
// In-order result FIFO for the coprocessor execution stage.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all entries)
//   push, wdata   : write one entry
//   pop           : discard the head entry (caller guarantees non-empty)
//   head          : oldest entry
//   full, empty   : occupancy flags derived from the registered count
module cvxif_result_fifo
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  exec_result_t wdata,
  input  logic         pop,
  output exec_result_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  exec_result_t mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DepthC);
  assign empty = (count == '0);

endmodule

// File: rtl/cvxif_copro_exec.sv
// Execution stage of the CV-X-IF example coprocessor.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   issue_valid_i / issue_ready_o : decoded-operation handshake
//   opcode_i, rs_i {rs3,rs2,rs1}  : operation and operands
//   shamt_i, lo_sel_i             : ROR64H rotate amount and word select
//   id_i, rd_i, we_i              : instruction id, destination, writeback request
//   result_*                      : CV-X-IF result channel (FIFO head, valid/ready)
// Single-cycle ops push at the accept edge; ADD_MULTI pushes MultiLat-1 edges later.
module cvxif_copro_exec
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned XLEN     = CoproXlen,
  parameter int unsigned IdWidth  = CoproIdWidth,
  parameter int unsigned Depth    = 2,
  parameter int unsigned MultiLat = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  opcode_t             opcode_i,
  input  logic [3*XLEN-1:0]   rs_i,
  input  logic [5:0]          shamt_i,
  input  logic                lo_sel_i,
  input  logic [IdWidth-1:0]  id_i,
  input  logic [4:0]          rd_i,
  input  logic                we_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [XLEN-1:0]     result_data_o,
  output logic [IdWidth-1:0]  result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int unsigned CntW = $clog2(MultiLat) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [CntW-1:0]     cnt;
  logic [XLEN-1:0]     multi_a, multi_b;
  logic [IdWidth-1:0]  multi_id;
  logic [4:0]          multi_rd;
  logic                multi_we;

  logic [XLEN-1:0] rs1, rs2, rs3;
  logic [XLEN-1:0] alu_data;
  logic            alu_we;
  logic            accept, is_multi;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  exec_result_t    push_entry, head;

  assign rs1 = rs_i[XLEN-1:0];
  assign rs2 = rs_i[2*XLEN-1:XLEN];
  assign rs3 = rs_i[3*XLEN-1:2*XLEN];

  always_comb begin
    alu_data = '0;
    alu_we   = we_i;
    case (opcode_i)
      ADD, ADD_MULTI:           alu_data = rs1 + rs2;
      DOUBLE_RS1:               alu_data = rs1 + rs1;
      DOUBLE_RS2:               alu_data = rs2 + rs2;
      ADD_RS3_R, MADD_RS3_R4:   alu_data = rs1 + rs2 + rs3;
      MSUB_RS3_R4:              alu_data = rs1 + rs2 - rs3;
      NMADD_RS3_R4:             alu_data = '0 - (rs1 + rs2 + rs3);
      NMSUB_RS3_R4:             alu_data = rs3 - (rs1 + rs2);
      ROR64H:                   alu_data = ror64_word(rs1, rs2, shamt_i, lo_sel_i);
      default: begin
        // NOP, ILLEGAL, OP_ASCON still retire their id with an empty result.
        alu_data = '0;
        alu_we   = 1'b0;
      end
    endcase
  end

  // Full is count==Depth on the registered count, so a pop this cycle only
  // re-opens ready on the next cycle.
  assign issue_ready_o = (state == IDLE) && !fifo_full;
  assign accept        = issue_valid_i && issue_ready_o;
  assign is_multi      = (opcode_i == ADD_MULTI);

  always_comb begin
    fifo_push  = 1'b0;
    push_entry = '0;
    if (state == BUSY) begin
      if (cnt == CntW'(1)) begin
        fifo_push       = 1'b1;
        push_entry.data = multi_a + multi_b;
        push_entry.id   = multi_id;
        push_entry.rd   = multi_rd;
        push_entry.we   = multi_we;
      end
    end else if (accept && !is_multi) begin
      fifo_push       = 1'b1;
      push_entry.data = alu_data;
      push_entry.id   = id_i;
      push_entry.rd   = rd_i;
      push_entry.we   = alu_we;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      multi_a  <= '0;
      multi_b  <= '0;
      multi_id <= '0;
      multi_rd <= '0;
      multi_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_multi) begin
            state    <= BUSY;
            cnt      <= CntW'(MultiLat - 1);
            multi_a  <= rs1;
            multi_b  <= rs2;
            multi_id <= id_i;
            multi_rd <= rd_i;
            multi_we <= we_i;
          end
        end
        BUSY: begin
          if (cnt == CntW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_pop = result_ready_i && !fifo_empty;

  cvxif_result_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .wdata  (push_entry),
    .pop    (fifo_pop),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign result_valid_o = !fifo_empty;
  assign result_data_o  = head.data;
  assign result_id_o    = head.id;
  assign result_rd_o    = head.rd;
  assign result_we_o    = head.we;

endmodule

// File: tb/tb_cvxif_copro_exec.sv
// Directed bench for cvxif_copro_exec: inputs change on the falling edge,
// outputs are sampled on the falling edge or 1 ns after the rising edge.
module tb_cvxif_copro_exec;
  import cvxif_instr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  opcode_t     opcode = NOP;
  logic [95:0] rs = '0;
  logic [5:0]  shamt = '0;
  logic        lo_sel = 1'b0;
  logic [3:0]  id = '0;
  logic [4:0]  rd = '0;
  logic        we = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result_data;
  logic [3:0]  result_id;
  logic [4:0]  result_rd;
  logic        result_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cvxif_copro_exec #(
    .XLEN     (32),
    .IdWidth  (4),
    .Depth    (2),
    .MultiLat (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .opcode_i       (opcode),
    .rs_i           (rs),
    .shamt_i        (shamt),
    .lo_sel_i       (lo_sel),
    .id_i           (id),
    .rd_i           (rd),
    .we_i           (we),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_data_o  (result_data),
    .result_id_o    (result_id),
    .result_rd_o    (result_rd),
    .result_we_o    (result_we)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [5:0] sh, input logic lo,
                        input logic [3:0] i, input logic [4:0] r, input logic w);
    opcode = op;
    rs     = {c, b, a};
    shamt  = sh;
    lo_sel = lo;
    id     = i;
    rd     = r;
    we     = w;
  endtask

  // Present one operation and hold it until the DUT accepts it (bounded).
  task automatic do_issue(input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [5:0] sh, input logic lo,
                          input logic [3:0] i, input logic [4:0] r, input logic w);
    int n;
    @(negedge clk);
    set_op(op, a, b, c, sh, lo, i, r, w);
    issue_valid = 1'b1;
    n = 0;
    while (!issue_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept", {31'd0, issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  // Check the head entry on the next falling edge, then pop it.
  task automatic expect_head(input string tag, input logic [31:0] d, input logic [3:0] i,
                             input logic [4:0] r, input logic w);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    chk({tag, "_data"},  result_data, d);
    chk({tag, "_id"},    {28'd0, result_id}, {28'd0, i});
    chk({tag, "_rd"},    {27'd0, result_rd}, {27'd0, r});
    chk({tag, "_we"},    {31'd0, result_we}, {31'd0, w});
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int low;
    logic last_valid;

    // Reset state
    #1;
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_data",  result_data, 32'd0);
    chk("rst_id",    {28'd0, result_id}, 32'd0);
    chk("rst_rd",    {27'd0, result_rd}, 32'd0);
    chk("rst_we",    {31'd0, result_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);

    // ADD with wrap, visible one cycle after accept
    do_issue(ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 6'd0, 1'b0, 4'd3, 5'd5, 1'b1);
    expect_head("add_wrap", 32'h0000_0001, 4'd3, 5'd5, 1'b1);
    @(negedge clk);
    chk("add_drained", {31'd0, result_valid}, 32'd0);

    // ROR64H word selects and zero shift
    do_issue(ROR64H, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 6'd8, 1'b0, 4'd1, 5'd1, 1'b1);
    expect_head("ror_hi", 32'hF012_3456, 4'd1, 5'd1, 1'b1);
    do_issue(ROR64H, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 6'd8, 1'b1, 4'd2, 5'd2, 1'b1);
    expect_head("ror_lo", 32'h789A_BCDE, 4'd2, 5'd2, 1'b1);
    do_issue(ROR64H, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 6'd0, 1'b0, 4'd3, 5'd3, 1'b1);
    expect_head("ror_zero", 32'h1234_5678, 4'd3, 5'd3, 1'b1);
    do_issue(ROR64H, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 6'd32, 1'b0, 4'd4, 5'd4, 1'b1);
    expect_head("ror_32", 32'h9ABC_DEF0, 4'd4, 5'd4, 1'b1);

    // Three-operand arithmetic and doubling
    do_issue(NMSUB_RS3_R4, 32'd1, 32'd2, 32'd10, 6'd0, 1'b0, 4'd5, 5'd6, 1'b1);
    expect_head("nmsub", 32'd7, 4'd5, 5'd6, 1'b1);
    do_issue(NMADD_RS3_R4, 32'd1, 32'd2, 32'd3, 6'd0, 1'b0, 4'd6, 5'd7, 1'b1);
    expect_head("nmadd", 32'hFFFF_FFFA, 4'd6, 5'd7, 1'b1);
    do_issue(MSUB_RS3_R4, 32'd5, 32'd6, 32'd1, 6'd0, 1'b0, 4'd7, 5'd8, 1'b1);
    expect_head("msub", 32'd10, 4'd7, 5'd8, 1'b1);
    do_issue(MADD_RS3_R4, 32'd5, 32'd6, 32'd7, 6'd0, 1'b0, 4'd8, 5'd9, 1'b0);
    expect_head("madd", 32'd18, 4'd8, 5'd9, 1'b0);
    do_issue(DOUBLE_RS2, 32'd9, 32'h8000_0001, 32'd0, 6'd0, 1'b0, 4'd9, 5'd10, 1'b1);
    expect_head("dbl_rs2", 32'd2, 4'd9, 5'd10, 1'b1);
    do_issue(DOUBLE_RS1, 32'd21, 32'd9, 32'd0, 6'd0, 1'b0, 4'd10, 5'd11, 1'b1);
    expect_head("dbl_rs1", 32'd42, 4'd10, 5'd11, 1'b1);
    do_issue(OP_ASCON, 32'd5, 32'd6, 32'd7, 6'd0, 1'b0, 4'd11, 5'd12, 1'b1);
    expect_head("ascon", 32'd0, 4'd11, 5'd12, 1'b0);

    // ADD_MULTI, then an ADD held valid behind it
    do_issue(ADD_MULTI, 32'd7, 32'd8, 32'd0, 6'd0, 1'b0, 4'd1, 5'd2, 1'b1);
    set_op(ADD, 32'd100, 32'd23, 32'd0, 6'd0, 1'b0, 4'd2, 5'd3, 1'b1);
    issue_valid = 1'b1;
    low = 0;
    last_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (issue_ready) break;
      low++;
      last_valid = result_valid;
    end
    chk("multi_ready_low", low, 32'd3);
    chk("multi_not_early", {31'd0, last_valid}, 32'd0);
    chk("multi_on_time", {31'd0, result_valid}, 32'd1);
    chk("multi_data_now", result_data, 32'd15);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    expect_head("multi", 32'd15, 4'd1, 5'd2, 1'b1);
    expect_head("after_multi", 32'd123, 4'd2, 5'd3, 1'b1);

    // Backpressure with NOPs: FIFO fills, a pop re-opens ready one cycle later
    do_issue(NOP, 32'd1, 32'd2, 32'd3, 6'd0, 1'b0, 4'd4, 5'd7, 1'b1);
    do_issue(NOP, 32'd1, 32'd2, 32'd3, 6'd0, 1'b0, 4'd5, 5'd7, 1'b1);
    @(negedge clk);
    chk("full_ready", {31'd0, issue_ready}, 32'd0);
    chk("full_head_id", {28'd0, result_id}, 32'd4);
    chk("full_head_data", result_data, 32'd0);
    chk("full_head_we", {31'd0, result_we}, 32'd0);
    set_op(NOP, 32'd1, 32'd2, 32'd3, 6'd0, 1'b0, 4'd6, 5'd7, 1'b1);
    issue_valid  = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    chk("pop_no_accept_head", {28'd0, result_id}, 32'd5);
    @(negedge clk);
    chk("reopen_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("refull_ready", {31'd0, issue_ready}, 32'd0);
    expect_head("nop_b", 32'd0, 4'd5, 5'd7, 1'b0);
    expect_head("nop_c", 32'd0, 4'd6, 5'd7, 1'b0);

    // Reset mid-BUSY with one buffered entry
    do_issue(ADD, 32'd1, 32'd1, 32'd0, 6'd0, 1'b0, 4'd7, 5'd1, 1'b1);
    do_issue(ADD_MULTI, 32'd3, 32'd4, 32'd0, 6'd0, 1'b0, 4'd8, 5'd2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, result_valid}, 32'd0);
    chk("midrst_data", result_data, 32'd0);
    chk("midrst_ready", {31'd0, issue_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("postrst_no_stale", {31'd0, result_valid}, 32'd0);
    do_issue(ADD, 32'd10, 32'd20, 32'd0, 6'd0, 1'b0, 4'd9, 5'd4, 1'b1);
    expect_head("postrst_add", 32'd30, 4'd9, 5'd4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
